// File: rtl/acl_spi_responder.sv
// ADXL362-style SPI responder: mode-0 slave, oversampled in the Clk domain,
// serving ID registers, coherent X/Y/Z snapshots and two writable controls.
module acl_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] DEVID_MST   = 8'h1D,
  parameter logic [7:0] PARTID      = 8'hF2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        sclk,
  input  logic        csn,
  input  logic        mosi,
  output logic        miso,
  input  logic [11:0] x_data,
  input  logic [11:0] y_data,
  input  logic [11:0] z_data,
  output logic [7:0]  power_ctl,
  output logic [7:0]  filter_ctl,
  output logic        txn_done,
  output logic [7:0]  txn_count
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA_RD, DATA_WR, IGNORE} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, mosi_sync;
  logic sclk_d, csn_d;
  logic sclk_s, csn_s, mosi_s;
  logic sclk_rise, sclk_fall, csn_rise, csn_fall;

  logic [7:0]  bit_cnt, bit_cnt_inc;
  logic [6:0]  rx_sr;
  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        cmd_rd;
  logic [7:0]  addr_reg;
  logic [7:0]  tx_sr;
  logic [7:0]  rd_addr, rd_data;
  logic [11:0] x_snap, y_snap, z_snap;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign csn_s  = csn_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // csn rising edge wins over any sclk edge in the same cycle
  assign csn_rise  = csn_s & ~csn_d;
  assign csn_fall  = ~csn_s & csn_d;
  assign sclk_rise = sclk_s & ~sclk_d & ~csn_rise;
  assign sclk_fall = ~sclk_s & sclk_d & ~csn_rise;

  assign bit_cnt_inc = (bit_cnt == 8'hFF) ? 8'hFF : bit_cnt + 8'd1;
  assign rx_byte     = {rx_sr, mosi_s};
  assign byte_done   = sclk_rise && (state_reg != IDLE) && (bit_cnt_inc[2:0] == 3'd0);

  // Synchronizers and one-cycle-delayed copies for edge detection. The csn
  // chain resets low so that a csn already low at reset release is not seen
  // as a new falling edge; the resulting rise in IDLE is harmless.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sclk_sync <= '0;
      csn_sync  <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      csn_d     <= csn_s;
    end
  end

  // Register read mux: the address phase looks up the freshly shifted
  // address, the data phase looks ahead to the auto-incremented one.
  assign rd_addr = (state_reg == ADDR) ? rx_byte : addr_reg + 8'd1;

  // Register map lookup; unmapped addresses read as zero
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      8'h00: rd_data = DEVID_AD;
      8'h01: rd_data = DEVID_MST;
      8'h02: rd_data = PARTID;
      8'h08: rd_data = x_snap[11:4];
      8'h09: rd_data = y_snap[11:4];
      8'h0A: rd_data = z_snap[11:4];
      8'h0E: rd_data = x_snap[7:0];
      8'h0F: rd_data = {{4{x_snap[11]}}, x_snap[11:8]};
      8'h10: rd_data = y_snap[7:0];
      8'h11: rd_data = {{4{y_snap[11]}}, y_snap[11:8]};
      8'h12: rd_data = z_snap[7:0];
      8'h13: rd_data = {{4{z_snap[11]}}, z_snap[11:8]};
      8'h2C: rd_data = filter_ctl;
      8'h2D: rd_data = power_ctl;
      default: rd_data = 8'h00;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state: byte boundaries advance the phase, csn rise aborts
  always_comb begin
    state_next = state_reg;
    if (csn_rise) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (csn_fall) state_next = CMD;
        CMD:  if (byte_done)
                state_next = (rx_byte == 8'h0A || rx_byte == 8'h0B) ? ADDR : IGNORE;
        ADDR: if (byte_done) state_next = cmd_rd ? DATA_RD : DATA_WR;
        default: state_next = state_reg;
      endcase
    end
  end

  // Bit/byte tracking, address handling, tx shifter and snapshot capture
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bit_cnt  <= 8'd0;
      rx_sr    <= 7'd0;
      cmd_rd   <= 1'b0;
      addr_reg <= 8'd0;
      tx_sr    <= 8'd0;
      x_snap   <= 12'd0;
      y_snap   <= 12'd0;
      z_snap   <= 12'd0;
    end else if (state_reg == IDLE && csn_fall) begin
      bit_cnt <= 8'd0;
      x_snap  <= x_data;
      y_snap  <= y_data;
      z_snap  <= z_data;
    end else if (sclk_rise && state_reg != IDLE) begin
      bit_cnt <= bit_cnt_inc;
      rx_sr   <= rx_byte[6:0];
      if (byte_done) begin
        case (state_reg)
          CMD:     cmd_rd <= (rx_byte == 8'h0B);
          ADDR: begin
            addr_reg <= rx_byte;
            if (cmd_rd) tx_sr <= rd_data;
          end
          DATA_RD: begin
            addr_reg <= addr_reg + 8'd1;
            tx_sr    <= rd_data;
          end
          DATA_WR: addr_reg <= addr_reg + 8'd1;
          default: ;
        endcase
      end
    end else if (sclk_fall && state_reg == DATA_RD) begin
      tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  // Writable control registers, updated only on a completed data byte
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      power_ctl  <= 8'h00;
      filter_ctl <= 8'h13;
    end else if (byte_done && state_reg == DATA_WR) begin
      if (addr_reg == 8'h2C) filter_ctl <= rx_byte;
      if (addr_reg == 8'h2D) power_ctl  <= rx_byte;
    end
  end

  // miso: next tx bit on each sclk fall while reading, zero otherwise
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                miso <= 1'b0;
    else if (csn_rise)                        miso <= 1'b0;
    else if (sclk_fall && state_reg == DATA_RD) miso <= tx_sr[7];
    else if (state_reg != DATA_RD)            miso <= 1'b0;
  end

  // Transaction completion pulse and wrapping counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      txn_done  <= 1'b0;
      txn_count <= 8'h00;
    end else begin
      txn_done <= csn_rise && (state_reg != IDLE);
      if (csn_rise && state_reg != IDLE) txn_count <= txn_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_acl_spi_responder.sv
// Directed testbench for acl_spi_responder: drives a mode-0 SPI master at
// 1/16 of Clk and checks read data, writes, snapshots and abort cases.
module tb_acl_spi_responder;

  localparam int HALF = 8;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        sclk, csn, mosi;
  logic        miso;
  logic [11:0] x_data, y_data, z_data;
  logic [7:0]  power_ctl, filter_ctl, txn_count;
  logic        txn_done;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int exp_count = 0;

  acl_spi_responder dut (
    .Clk(Clk), .Reset(Reset), .sclk(sclk), .csn(csn), .mosi(mosi), .miso(miso),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .power_ctl(power_ctl), .filter_ctl(filter_ctl),
    .txn_done(txn_done), .txn_count(txn_count)
  );

  always #5 Clk = ~Clk;

  // counts Clk cycles with txn_done high, so a stretched pulse shows up
  always @(posedge Clk) if (txn_done === 1'b1) pulses++;

  task automatic wait_half();
    repeat (HALF) @(negedge Clk);
  endtask

  task automatic spi_begin();
    @(negedge Clk);
    csn = 1'b0;
    wait_half();
  endtask

  task automatic spi_end();
    wait_half();
    csn = 1'b1;
    repeat (2 * HALF) @(negedge Clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      wait_half();
      rx[i] = miso;
      sclk = 1'b1;
      wait_half();
      sclk = 1'b0;
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      wait_half();
      sclk = 1'b1;
      wait_half();
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; csn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    x_data = 12'h000; y_data = 12'h000; z_data = 12'h000;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    repeat (2 * HALF) @(negedge Clk);
    n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso got %b want 0", miso); end
    n_cmp++; if (power_ctl !== 8'h00) begin n_bad++; $display("FAIL reset_power got %h want 00", power_ctl); end
    n_cmp++; if (filter_ctl !== 8'h13) begin n_bad++; $display("FAIL reset_filter got %h want 13", filter_ctl); end
    n_cmp++; if (txn_done !== 1'b0) begin n_bad++; $display("FAIL reset_txn_done got %b want 0", txn_done); end
    n_cmp++; if (txn_count !== 8'h00) begin n_bad++; $display("FAIL reset_count got %h want 00", txn_count); end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL reset_pulses got %0d want 0", pulses); end
    $display("txn reset: power=%h filter=%h count=%h", power_ctl, filter_ctl, txn_count);
  endtask

  task automatic test_read_id();
    logic [7:0] rc, ra, r0, r1, r2;
    int p0;
    p0 = pulses;
    spi_begin();
    spi_byte(8'h0B, rc); spi_byte(8'h00, ra);
    spi_byte(8'h00, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2);
    spi_end();
    exp_count++;
    $display("txn read 0x00: %h %h %h count=%h", r0, r1, r2, txn_count);
    n_cmp++; if ({rc, ra} !== 16'h0000) begin n_bad++; $display("FAIL id_hdr_miso got %h want 0000", {rc, ra}); end
    n_cmp++; if (r0 !== 8'hAD) begin n_bad++; $display("FAIL id_devid_ad got %h want AD", r0); end
    n_cmp++; if (r1 !== 8'h1D) begin n_bad++; $display("FAIL id_devid_mst got %h want 1D", r1); end
    n_cmp++; if (r2 !== 8'hF2) begin n_bad++; $display("FAIL id_partid got %h want F2", r2); end
    n_cmp++; if (txn_count !== 8'(exp_count)) begin n_bad++; $display("FAIL id_count got %h want %h", txn_count, 8'(exp_count)); end
    n_cmp++; if (pulses - p0 !== 1) begin n_bad++; $display("FAIL id_pulse got %0d want 1", pulses - p0); end
  endtask

  task automatic test_snapshot();
    logic [7:0] d, r0, r1, r2, r3;
    x_data = 12'hF85;
    spi_begin();
    x_data = 12'h123;  // changed after csn fall: must not be seen
    spi_byte(8'h0B, d); spi_byte(8'h0E, d);
    spi_byte(8'h00, r0); spi_byte(8'h00, r1);
    spi_end();
    exp_count++;
    $display("txn read 0x0E: %h %h", r0, r1);
    n_cmp++; if (r0 !== 8'h85) begin n_bad++; $display("FAIL snap_xlo got %h want 85", r0); end
    n_cmp++; if (r1 !== 8'hFF) begin n_bad++; $display("FAIL snap_xhi got %h want FF", r1); end

    y_data = 12'hABC; z_data = 12'h7F0;
    spi_begin();
    spi_byte(8'h0B, d); spi_byte(8'h08, d);
    spi_byte(8'h00, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2);
    spi_end();
    exp_count++;
    $display("txn read 0x08: %h %h %h", r0, r1, r2);
    n_cmp++; if ({r0, r1, r2} !== 24'h12AB7F) begin n_bad++; $display("FAIL xyz_msb got %h want 12AB7F", {r0, r1, r2}); end

    spi_begin();
    spi_byte(8'h0B, d); spi_byte(8'h10, d);
    spi_byte(8'h00, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2); spi_byte(8'h00, r3);
    spi_end();
    exp_count++;
    $display("txn read 0x10: %h %h %h %h", r0, r1, r2, r3);
    n_cmp++; if ({r0, r1, r2, r3} !== 32'hBCFAF007) begin n_bad++; $display("FAIL yz_lohi got %h want BCFAF007", {r0, r1, r2, r3}); end
  endtask

  task automatic test_write();
    logic [7:0] d, r0;
    spi_begin();
    spi_byte(8'h0A, d); spi_byte(8'h2D, d); spi_byte(8'h02, d);
    n_cmp++; if (power_ctl !== 8'h02) begin n_bad++; $display("FAIL wr_power got %h want 02", power_ctl); end
    spi_end();
    exp_count++;
    $display("txn write 0x2D=02: power=%h", power_ctl);

    spi_begin();
    spi_byte(8'h0A, d); spi_byte(8'h00, d); spi_byte(8'h55, d);
    spi_end();
    exp_count++;
    spi_begin();
    spi_byte(8'h0B, d); spi_byte(8'h00, d); spi_byte(8'h00, r0);
    spi_end();
    exp_count++;
    $display("txn read 0x00 after write: %h", r0);
    n_cmp++; if (r0 !== 8'hAD) begin n_bad++; $display("FAIL wr_readonly got %h want AD", r0); end
  endtask

  task automatic test_auto_increment();
    logic [7:0] d, r0, r1;
    spi_begin();
    spi_byte(8'h0A, d); spi_byte(8'h2D, d); spi_byte(8'h00, d);
    spi_end();
    exp_count++;
    spi_begin();
    spi_byte(8'h0A, d); spi_byte(8'h2C, d); spi_byte(8'h11, d); spi_byte(8'h02, d);
    spi_end();
    exp_count++;
    $display("txn write 0x2C=11,02: filter=%h power=%h", filter_ctl, power_ctl);
    n_cmp++; if (filter_ctl !== 8'h11) begin n_bad++; $display("FAIL inc_filter got %h want 11", filter_ctl); end
    n_cmp++; if (power_ctl !== 8'h02) begin n_bad++; $display("FAIL inc_power got %h want 02", power_ctl); end

    spi_begin();
    spi_byte(8'h0B, d); spi_byte(8'hFF, d); spi_byte(8'h00, r0); spi_byte(8'h00, r1);
    spi_end();
    exp_count++;
    $display("txn read 0xFF: %h %h", r0, r1);
    n_cmp++; if ({r0, r1} !== 16'h00AD) begin n_bad++; $display("FAIL wrap_read got %h want 00AD", {r0, r1}); end
    n_cmp++; if (txn_count !== 8'(exp_count)) begin n_bad++; $display("FAIL inc_count got %h want %h", txn_count, 8'(exp_count)); end
  endtask

  task automatic test_bad_command();
    logic [7:0] d, r0, r1;
    int p0;
    p0 = pulses;
    spi_begin();
    spi_byte(8'h0C, d); spi_byte(8'h2D, r0); spi_byte(8'hFF, r1);
    spi_end();
    exp_count++;
    $display("txn cmd 0x0C: %h %h power=%h count=%h", r0, r1, power_ctl, txn_count);
    n_cmp++; if ({r0, r1} !== 16'h0000) begin n_bad++; $display("FAIL bad_cmd_miso got %h want 0000", {r0, r1}); end
    n_cmp++; if ({filter_ctl, power_ctl} !== 16'h1102) begin n_bad++; $display("FAIL bad_cmd_regs got %h want 1102", {filter_ctl, power_ctl}); end
    n_cmp++; if (txn_count !== 8'(exp_count)) begin n_bad++; $display("FAIL bad_cmd_count got %h want %h", txn_count, 8'(exp_count)); end
    n_cmp++; if (pulses - p0 !== 1) begin n_bad++; $display("FAIL bad_cmd_pulse got %0d want 1", pulses - p0); end
  endtask

  task automatic test_partial_write();
    logic [7:0] d;
    int p0;
    p0 = pulses;
    spi_begin();
    spi_byte(8'h0A, d); spi_byte(8'h2D, d); spi_bits(8'hF0, 4);
    spi_end();
    exp_count++;
    $display("txn partial write 0x2D: power=%h count=%h", power_ctl, txn_count);
    n_cmp++; if (power_ctl !== 8'h02) begin n_bad++; $display("FAIL partial_power got %h want 02", power_ctl); end
    n_cmp++; if (txn_count !== 8'(exp_count)) begin n_bad++; $display("FAIL partial_count got %h want %h", txn_count, 8'(exp_count)); end
    n_cmp++; if (pulses - p0 !== 1) begin n_bad++; $display("FAIL partial_pulse got %0d want 1", pulses - p0); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d, r0;
    spi_begin();
    spi_byte(8'h0B, d); spi_byte(8'h00, d); spi_bits(8'h00, 3);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    $display("txn reset mid-read: miso=%b power=%h count=%h", miso, power_ctl, txn_count);
    n_cmp++; if (miso !== 1'b0) begin n_bad++; $display("FAIL midrst_miso got %b want 0", miso); end
    n_cmp++; if (power_ctl !== 8'h00) begin n_bad++; $display("FAIL midrst_power got %h want 00", power_ctl); end
    n_cmp++; if (filter_ctl !== 8'h13) begin n_bad++; $display("FAIL midrst_filter got %h want 13", filter_ctl); end
    n_cmp++; if (txn_count !== 8'h00) begin n_bad++; $display("FAIL midrst_count got %h want 00", txn_count); end
    @(negedge Clk);
    csn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    exp_count = 0;
    repeat (2 * HALF) @(negedge Clk);
    n_cmp++; if (txn_count !== 8'h00) begin n_bad++; $display("FAIL post_rst_count got %h want 00", txn_count); end

    spi_begin();
    spi_byte(8'h0B, d); spi_byte(8'h00, d); spi_byte(8'h00, r0);
    spi_end();
    exp_count++;
    $display("txn read after reset: %h count=%h", r0, txn_count);
    n_cmp++; if (r0 !== 8'hAD) begin n_bad++; $display("FAIL post_rst_read got %h want AD", r0); end
    n_cmp++; if (txn_count !== 8'(exp_count)) begin n_bad++; $display("FAIL post_rst_txn got %h want %h", txn_count, 8'(exp_count)); end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_snapshot();
    test_write();
    test_auto_increment();
    test_bad_command();
    test_partial_write();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acl_spi_responder.md
Name: acl_spi_responder

Overview:
- SPI slave that emulates the ADXL362 accelerometer end of the link driven by spi_master.
- Lets doodle_top and the tilt path be simulated, or run on a board without the sensor, with programmable X/Y/Z tilt values.
- Oversamples SCLK, CSN and MOSI in the system clock domain.
- Decodes the ADXL362 read (0x0B) and write (0x0A) commands, with address auto-increment, and serves a small register map.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on sclk, csn and mosi (minimum 2).
- DEVID_AD, 8'hAD: value returned at address 0x00.
- DEVID_MST, 8'h1D: value returned at address 0x01.
- PARTID, 8'hF2: value returned at address 0x02.

Ports:
- Clk  in  1  system clock; must be at least 8x the SCLK frequency.
- Reset  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
- csn  in  1  SPI chip select, active low.
- mosi  in  1  master-out data, MSB first.
- miso  out  1  slave-out data, MSB first; 0 whenever not driving data.
- x_data  in  12  X acceleration, two's complement.
- y_data  in  12  Y acceleration, two's complement.
- z_data  in  12  Z acceleration, two's complement.
- power_ctl  out  8  POWER_CTL register (0x2D) contents.
- filter_ctl  out  8  FILTER_CTL register (0x2C) contents.
- txn_done  out  1  one-Clk pulse at the csn rising edge of any transaction.
- txn_count  out  8  completed-transaction counter; wraps 0xFF->0x00.

Behaviour:
- Interface: one clock (Clk); reset (Reset) is asynchronous and active-high.
- Reset values: miso=0, power_ctl=0x00, filter_ctl=0x13, txn_done=0, txn_count=0x00, state=IDLE, bit counter=0, snapshots=0.
- Synchronizing: sclk, csn and mosi pass through SYNC_STAGES flops. Edges are detected on the synchronized signals by comparing against a one-cycle-delayed copy.
- Mosi is sampled on the synchronized sclk rising edge. Miso updates on the synchronized sclk falling edge.
- Snapshot: on the csn falling edge, x_data, y_data and z_data are captured into snapshot registers. All reads within the transaction use the snapshot, so the X/Y/Z values are coherent.
- Register map; unlisted addresses read 0x00:
  - 0x00 DEVID_AD, 0x01 DEVID_MST, 0x02 PARTID.
  - 0x08/0x09/0x0A: X/Y/Z [11:4].
  - 0x0E/0x10/0x12: X/Y/Z [7:0].
  - 0x0F/0x11/0x13: {4 sign bits, [11:8]} of X/Y/Z.
  - 0x2C FILTER_CTL and 0x2D POWER_CTL are read/write. All other addresses are read-only; writes to them are ignored.
- FSM states: IDLE, CMD, ADDR, DATA_RD, DATA_WR, IGNORE.
  - IDLE -> CMD on csn falling edge; bit counter cleared.
  - CMD -> ADDR after the 8th rising edge if the command byte is 0x0A or 0x0B. Any other command byte goes to IGNORE.
  - ADDR -> DATA_RD or DATA_WR after the 16th rising edge; the address register is loaded from the shifted byte.
  - DATA_RD: on the 16th rising edge, the tx shift register loads reg[addr]. On the following falling edge, miso = bit7. Each later falling edge shifts the next bit out. On every 8th rising edge after that, addr increments and the next byte loads, with its MSB presented on the next falling edge.
  - DATA_WR: on each 8th rising edge of a data byte, the byte is written to reg[addr] if writable, then addr increments.
  - IGNORE: miso held 0 until csn rises.
  - Any state -> IDLE on csn rising edge. txn_done pulses one Clk, txn_count increments, miso is forced 0.
- Address auto-increment is 8 bits and wraps 0xFF->0x00.
- Boundaries:
  - csn rise mid-byte: the partial byte is discarded and no write occurs. txn_done still pulses.
  - csn rising edge in the same Clk as an sclk edge: csn wins and the sclk edge is ignored.
  - sclk edges while csn is high are ignored.
  - Reset mid-transaction: immediate return to reset values. The next transaction needs a fresh csn falling edge.
  - The bit counter saturates at 255 rising edges; byte tracking uses its low 3 bits.

Test Plan:
- Read 0x0B,0x00 followed by 3 dummy bytes -> miso returns 0xAD, 0x1D, 0xF2; txn_count=1; one txn_done pulse.
- x_data=12'hF85 and read 0x0B,0x0E with 2 bytes -> 0x85, 0xFF. Change x_data mid-read to 12'h123 -> the second byte is still 0xFF (snapshot).
- Write 0x0A,0x2D,0x02 -> power_ctl=0x02 after the 24th rising edge. Write 0x0A,0x00,0x55 -> DEVID still reads 0xAD.
- Write 0x0A,0x2C,0x11,0x02 -> filter_ctl=0x11 and power_ctl=0x02 (auto-increment). Read 0x0B,0xFF with 2 bytes -> 0x00, 0xAD (wrap).
- Command 0x0C with 2 bytes -> miso stays 0, no register change, txn_count increments.
- Write 0x0A,0x2D, then 4 bits of 0xF, then csn high -> power_ctl unchanged. Assert Reset mid-read -> miso=0, power_ctl=0x00, txn_count=0.
